// File: rtl/hid_key_encoder.sv
// hid_key_encoder: converts CPU-written ASCII characters into HID boot-keyboard press/release reports.
// Ports:
//   clk_i, rst_n_i           clock, synchronous active-low reset
//   wr_n, usb_cs             bus write strobe (active-low) and block select
//   reg_addr_i, data_i       register address and write data
//   data_o                   read data, combinational from reg_addr_i
//   rpt_valid, rpt_ready     report stream handshake
//   rpt_modifiers, rpt_key1  HID modifier byte and keycode
//   busy                     FSM active or characters queued
module hid_key_encoder #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] HOLD_CYCLES = 16'd50000,
  parameter logic [15:0] GAP_CYCLES  = 16'd50000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       wr_n,
  input  logic       usb_cs,
  input  logic [7:0] reg_addr_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       rpt_valid,
  input  logic       rpt_ready,
  output logic [7:0] rpt_modifiers,
  output logic [7:0] rpt_key1,
  output logic       busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, LOOKUP, PRESS, HOLD, RELEASE, GAP} state_t;

  // {mappable, modifier, keycode}
  function automatic logic [16:0] map_char(input logic [7:0] c);
    case (c) inside
      [8'h61:8'h7A]: map_char = {1'b1, 8'h00, 8'(c - 8'h5D)};
      [8'h41:8'h5A]: map_char = {1'b1, 8'h02, 8'(c - 8'h3D)};
      8'h08:         map_char = {1'b1, 8'h00, 8'd42};
      8'h09:         map_char = {1'b1, 8'h00, 8'd43};
      8'h0D:         map_char = {1'b1, 8'h00, 8'd40};
      [8'h01:8'h1A]: map_char = {1'b1, 8'h01, 8'(c + 8'h03)};
      [8'h31:8'h39]: map_char = {1'b1, 8'h00, 8'(c - 8'h13)};
      8'h30:         map_char = {1'b1, 8'h00, 8'd39};
      8'h1B:         map_char = {1'b1, 8'h00, 8'd41};
      8'h20:         map_char = {1'b1, 8'h00, 8'd44};
      8'h2D:         map_char = {1'b1, 8'h00, 8'd45};
      8'h3D:         map_char = {1'b1, 8'h00, 8'd46};
      8'h5B:         map_char = {1'b1, 8'h00, 8'd47};
      8'h5D:         map_char = {1'b1, 8'h00, 8'd48};
      8'h5C:         map_char = {1'b1, 8'h00, 8'd49};
      8'h3B:         map_char = {1'b1, 8'h00, 8'd51};
      8'h27:         map_char = {1'b1, 8'h00, 8'd52};
      8'h60:         map_char = {1'b1, 8'h00, 8'd53};
      8'h2C:         map_char = {1'b1, 8'h00, 8'd54};
      8'h2E:         map_char = {1'b1, 8'h00, 8'd55};
      8'h2F:         map_char = {1'b1, 8'h00, 8'd56};
      8'h21:         map_char = {1'b1, 8'h02, 8'd30};
      8'h40:         map_char = {1'b1, 8'h02, 8'd31};
      8'h23:         map_char = {1'b1, 8'h02, 8'd32};
      8'h24:         map_char = {1'b1, 8'h02, 8'd33};
      8'h25:         map_char = {1'b1, 8'h02, 8'd34};
      8'h5E:         map_char = {1'b1, 8'h02, 8'd35};
      8'h26:         map_char = {1'b1, 8'h02, 8'd36};
      8'h2A:         map_char = {1'b1, 8'h02, 8'd37};
      8'h28:         map_char = {1'b1, 8'h02, 8'd38};
      8'h29:         map_char = {1'b1, 8'h02, 8'd39};
      8'h5F:         map_char = {1'b1, 8'h02, 8'd45};
      8'h2B:         map_char = {1'b1, 8'h02, 8'd46};
      8'h7B:         map_char = {1'b1, 8'h02, 8'd47};
      8'h7D:         map_char = {1'b1, 8'h02, 8'd48};
      8'h7C:         map_char = {1'b1, 8'h02, 8'd49};
      8'h3A:         map_char = {1'b1, 8'h02, 8'd51};
      8'h22:         map_char = {1'b1, 8'h02, 8'd52};
      8'h7E:         map_char = {1'b1, 8'h02, 8'd53};
      8'h3C:         map_char = {1'b1, 8'h02, 8'd54};
      8'h3E:         map_char = {1'b1, 8'h02, 8'd55};
      8'h3F:         map_char = {1'b1, 8'h02, 8'd56};
      8'h88:         map_char = {1'b1, 8'h00, 8'd80};
      8'h89:         map_char = {1'b1, 8'h00, 8'd79};
      8'h8A:         map_char = {1'b1, 8'h00, 8'd81};
      8'h8B:         map_char = {1'b1, 8'h00, 8'd82};
      default:       map_char = 17'd0;
    endcase
  endfunction

  state_t        r_state;
  logic          r_sel_d, r_stb, r_ovf, r_err;
  logic [7:0]    r_addr, r_data, r_char;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;
  logic [15:0]   r_cnt;
  logic          w_sel, w_full, w_empty, w_push, w_pop, w_flush, w_clr;
  logic [16:0]   w_map;

  assign w_sel   = usb_cs && !wr_n;
  assign w_full  = r_count == (AW+1)'(FIFO_DEPTH);
  assign w_empty = r_count == '0;
  assign w_push  = r_stb && r_addr == 8'h00 && !w_full;
  assign w_pop   = r_state == IDLE && !w_empty;
  assign w_flush = r_stb && r_addr == 8'h01 && r_data[0];
  assign w_clr   = r_stb && r_addr == 8'h01 && r_data[1];
  assign w_map   = map_char(r_char);
  assign busy    = r_state != IDLE || !w_empty;
  assign data_o  = reg_addr_i == 8'h00 ? {5'd0, r_err, r_ovf, w_full} :
                   reg_addr_i == 8'h01 ? 8'(r_count) :
                   reg_addr_i == 8'h02 ? {7'd0, busy} : 8'h00;

  always_ff @(posedge clk_i)
    if (rst_n_i && w_push) r_mem[r_wp] <= r_data;

  // Bus strobe is captured on its first cycle; the FIFO acts on the captured copy one edge later.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_sel_d <= 1'b0;
      r_stb   <= 1'b0;
      r_addr  <= 8'h00;
      r_data  <= 8'h00;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_sel_d <= w_sel;
      r_stb   <= w_sel && !r_sel_d;
      if (w_sel && !r_sel_d) begin
        r_addr <= reg_addr_i;
        r_data <= data_i;
      end
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_flush) begin
        r_rp    <= r_wp;
        r_count <= '0;
      end else begin
        if (w_pop) r_rp <= r_rp + 1'b1;
        r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
      if (w_clr) r_ovf <= 1'b0;
      if (r_stb && r_addr == 8'h00 && w_full) r_ovf <= 1'b1;
      if (w_clr) r_err <= 1'b0;
      if (r_state == LOOKUP && !w_map[16]) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state       <= IDLE;
      r_char        <= 8'h00;
      r_cnt         <= 16'd0;
      rpt_valid     <= 1'b0;
      rpt_modifiers <= 8'h00;
      rpt_key1      <= 8'h00;
    end else begin
      case (r_state)
        IDLE: if (w_pop) begin
          r_char  <= r_mem[r_rp];
          r_state <= LOOKUP;
        end
        LOOKUP: if (w_map[16]) begin
          r_state       <= PRESS;
          rpt_valid     <= 1'b1;
          rpt_modifiers <= w_map[15:8];
          rpt_key1      <= w_map[7:0];
        end else r_state <= IDLE;
        PRESS: if (rpt_ready) begin
          r_state       <= HOLD;
          r_cnt         <= HOLD_CYCLES;
          rpt_valid     <= 1'b0;
          rpt_modifiers <= 8'h00;
          rpt_key1      <= 8'h00;
        end
        HOLD: if (r_cnt == 16'd0) begin
          r_state   <= RELEASE;
          rpt_valid <= 1'b1;
        end else r_cnt <= r_cnt - 16'd1;
        RELEASE: if (rpt_ready) begin
          r_state   <= GAP;
          r_cnt     <= GAP_CYCLES;
          rpt_valid <= 1'b0;
        end
        GAP: if (r_cnt == 16'd0) r_state <= IDLE;
        else r_cnt <= r_cnt - 16'd1;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hid_key_encoder.sv
// tb_hid_key_encoder: scoreboard bench for hid_key_encoder.
module tb_hid_key_encoder;
  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       wr_n = 1'b1;
  logic       usb_cs = 1'b0;
  logic [7:0] reg_addr_i = 8'h00;
  logic [7:0] data_i = 8'h00;
  logic [7:0] data_o;
  logic       rpt_valid;
  logic       rpt_ready = 1'b0;
  logic [7:0] rpt_modifiers, rpt_key1;
  logic       busy;
  int         n_chk = 0;
  int         n_err = 0;
  logic [15:0] sb[$];
  logic       p_stall = 1'b0;
  logic [15:0] p_pay = 16'h0;

  hid_key_encoder #(.FIFO_DEPTH(8), .HOLD_CYCLES(16'd4), .GAP_CYCLES(16'd4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .wr_n(wr_n), .usb_cs(usb_cs),
    .reg_addr_i(reg_addr_i), .data_i(data_i), .data_o(data_o),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_modifiers(rpt_modifiers),
    .rpt_key1(rpt_key1), .busy(busy)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    usb_cs = 1'b1; wr_n = 1'b0; reg_addr_i = a; data_i = d;
    tick(1);
    usb_cs = 1'b0; wr_n = 1'b1;
    tick(1);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    reg_addr_i = a;
    #1;
    chk(tag, 32'(data_o), 32'(exp));
  endtask

  task automatic exp_char(input logic [15:0] p);
    sb.push_back(p);
    sb.push_back(16'h0000);
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      tick(1);
      done = !busy && !rpt_valid && sb.size() == 0;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  // Reports are compared as they are accepted; a stalled report must not change.
  always @(negedge clk_i) begin
    if (!rst_n_i) p_stall = 1'b0;
    else begin
      if (p_stall) chk("stall_stable", 32'({rpt_valid, rpt_modifiers, rpt_key1}), 32'({1'b1, p_pay}));
      if (rpt_valid && rpt_ready) begin
        if (sb.size() == 0) chk("rpt_unexpected", 32'(sb.size()), 32'd1);
        else chk("rpt", 32'({rpt_modifiers, rpt_key1}), 32'(sb.pop_front()));
      end
      p_stall = rpt_valid && !rpt_ready;
      p_pay = {rpt_modifiers, rpt_key1};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    tick(3);
    chk("rst_valid", 32'(rpt_valid), 32'd0);
    chk("rst_payload", 32'({rpt_modifiers, rpt_key1}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rd_chk("rst_stat", 8'h00, 8'h00);
    rd_chk("rst_count", 8'h01, 8'h00);
    rst_n_i = 1'b1;
    tick(1);

    rpt_ready = 1'b1;
    exp_char(16'h0204);
    usb_cs = 1'b1; wr_n = 1'b0; reg_addr_i = 8'h00; data_i = 8'h41;
    tick(1);
    usb_cs = 1'b0; wr_n = 1'b1;
    tick(2);
    chk("lat_e2", 32'(rpt_valid), 32'd0);
    tick(1);
    chk("lat_e3", 32'({rpt_valid, rpt_modifiers, rpt_key1}), 32'h10204);
    tick(1);
    chk("press_done", 32'(rpt_valid), 32'd0);
    tick(4);
    chk("hold_e8", 32'(rpt_valid), 32'd0);
    tick(1);
    chk("release_e9", 32'({rpt_valid, rpt_modifiers, rpt_key1}), 32'h10000);
    wait_idle("t1_idle");

    exp_char(16'h0106);
    exp_char(16'h0028);
    exp_char(16'h0052);
    wr(8'h00, 8'h03);
    wr(8'h00, 8'h0D);
    wr(8'h00, 8'h8B);
    wait_idle("t2_idle");

    rpt_ready = 1'b0;
    exp_char(16'h001D);
    wr(8'h00, 8'h7A);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      seen = rpt_valid;
    end
    chk("t3_valid", 32'(seen), 32'd1);
    tick(20);
    chk("t3_held", 32'({rpt_valid, rpt_modifiers, rpt_key1}), 32'h1001D);
    rpt_ready = 1'b1;
    tick(1);
    chk("t3_accepted", 32'(rpt_valid), 32'd0);
    wait_idle("t3_idle");

    rpt_ready = 1'b0;
    exp_char(16'h0004);
    for (int i = 0; i < 10; i++) wr(8'h00, 8'(8'h61 + i));
    rd_chk("t4_stat", 8'h00, 8'h03);
    rd_chk("t4_count", 8'h01, 8'h08);
    rd_chk("t4_busy", 8'h02, 8'h01);
    wr(8'h01, 8'h03);
    rd_chk("t4_stat_clr", 8'h00, 8'h00);
    rd_chk("t4_count_clr", 8'h01, 8'h00);
    chk("t4_inflight", 32'({rpt_valid, rpt_modifiers, rpt_key1}), 32'h10004);
    rpt_ready = 1'b1;
    wait_idle("t4_idle");

    wr(8'h00, 8'h80);
    tick(5);
    rd_chk("t5_err", 8'h00, 8'h04);
    chk("t5_no_rpt", 32'(rpt_valid), 32'd0);
    exp_char(16'h0005);
    wr(8'h00, 8'h62);
    wait_idle("t5_idle");
    rd_chk("t5_err_sticky", 8'h00, 8'h04);
    wr(8'h01, 8'h02);
    rd_chk("t5_err_clr", 8'h00, 8'h00);

    sb.push_back(16'h0006);
    wr(8'h00, 8'h63);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      seen = sb.size() == 0;
    end
    chk("t6_press", 32'(seen), 32'd1);
    tick(2);
    rst_n_i = 1'b0;
    tick(1);
    chk("t6_valid", 32'(rpt_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    rd_chk("t6_count", 8'h01, 8'h00);
    rst_n_i = 1'b1;
    tick(30);
    chk("t6_no_release", 32'({rpt_valid, busy}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
